// File: rtl/sprite_motion_ctrl_if.sv
// Sprite motion controller bus: pixel counters,
// buttons and mode in; committed position and status out.
interface sprite_motion_ctrl_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        btn_up_in;
  logic        btn_down_in;
  logic        btn_left_in;
  logic        btn_right_in;
  logic        mode_in;
  logic [3:0]  speed_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        frame_tick_out;
  logic        busy_out;

  modport master (
    output hcount_in, vcount_in,
    output btn_up_in, btn_down_in,
    output btn_left_in, btn_right_in,
    output mode_in, speed_in,
    input  x_out, y_out,
    input  frame_tick_out, busy_out
  );

  modport slave (
    input  hcount_in, vcount_in,
    input  btn_up_in, btn_down_in,
    input  btn_left_in, btn_right_in,
    input  mode_in, speed_in,
    output x_out, y_out,
    output frame_tick_out, busy_out
  );
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position scheduler: computes a new
// (x,y) once per frame and commits it during vblank.
module sprite_motion_ctrl #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int SPRITE_W = 256,
  parameter int SPRITE_H = 256,
  parameter int X_INIT   = 0,
  parameter int Y_INIT   = 0
) (
  input logic pixel_clk_in,
  input logic rst_n_in,
  sprite_motion_ctrl_if.slave bus
);
  localparam int X_MAX = H_ACTIVE - SPRITE_W;
  localparam int Y_MAX = V_ACTIVE - SPRITE_H;
  localparam logic [10:0] X_RST = 11'(X_INIT);
  localparam logic [9:0]  Y_RST = 10'(Y_INIT);
  localparam logic [9:0]  V_DET = 10'(V_ACTIVE);

  typedef enum logic [2:0] {
    IDLE, LATCH, CALC_X, CALC_Y, COMMIT
  } state_t;

  typedef struct packed {
    logic        neg;
    logic [10:0] pos;
  } mv_t;

  // neg = 1 means the bounce direction is -1
  function automatic mv_t move(
    input logic [10:0] pos,
    input int          lim,
    input logic        fwd,
    input logic        rev,
    input logic        bnc,
    input logic        neg,
    input logic [3:0]  spd
  );
    logic signed [11:0] s;
    logic signed [11:0] d;
    logic signed [11:0] l;
    mv_t r;
    l = 12'(lim);
    d = {8'd0, spd};
    if (bnc) begin
      if (neg) d = -d;
    end else if (fwd == rev) begin
      d = '0;
    end else if (rev) begin
      d = -d;
    end
    s = $signed({1'b0, pos}) + d;
    r.neg = neg;
    if (bnc && spd != 4'd0) begin
      if (s >= l) begin
        s = l;
        r.neg = 1'b1;
      end else if (s <= 0) begin
        s = '0;
        r.neg = 1'b0;
      end
    end else if (s > l) begin
      s = l;
    end else if (s < 0) begin
      s = '0;
    end
    r.pos = s[10:0];
    return r;
  endfunction

  state_t      state;
  logic [1:0]  up_s, dn_s, lf_s, rt_s;
  logic        up_r, dn_r, lf_r, rt_r;
  logic        mode_r;
  logic [3:0]  speed_r;
  logic [10:0] x_r, x_nx;
  logic [9:0]  y_r;
  logic        dx, dy, dx_nx;
  logic        tick, busy;
  mv_t         mv_x, mv_y;
  logic        unused_ok;

  always_comb begin
    mv_x = move(x_r, X_MAX, rt_r, lf_r,
                mode_r, dx, speed_r);
    mv_y = move({1'b0, y_r}, Y_MAX, dn_r, up_r,
                mode_r, dy, speed_r);
  end

  assign unused_ok = mv_y.pos[10];

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state   <= IDLE;
      up_s    <= '0;
      dn_s    <= '0;
      lf_s    <= '0;
      rt_s    <= '0;
      up_r    <= 1'b0;
      dn_r    <= 1'b0;
      lf_r    <= 1'b0;
      rt_r    <= 1'b0;
      mode_r  <= 1'b0;
      speed_r <= '0;
      x_r     <= X_RST;
      y_r     <= Y_RST;
      x_nx    <= X_RST;
      dx      <= 1'b0;
      dy      <= 1'b0;
      dx_nx   <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      up_s <= {up_s[0], bus.btn_up_in};
      dn_s <= {dn_s[0], bus.btn_down_in};
      lf_s <= {lf_s[0], bus.btn_left_in};
      rt_s <= {rt_s[0], bus.btn_right_in};
      tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hcount_in == 11'd0 &&
              bus.vcount_in == V_DET) begin
            state <= LATCH;
            tick  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LATCH: begin
          mode_r  <= bus.mode_in;
          speed_r <= bus.speed_in;
          up_r    <= up_s[1];
          dn_r    <= dn_s[1];
          lf_r    <= lf_s[1];
          rt_r    <= rt_s[1];
          state   <= CALC_X;
        end
        CALC_X: begin
          x_nx  <= mv_x.pos;
          dx_nx <= mv_x.neg;
          state <= CALC_Y;
        end
        CALC_Y: begin
          x_r   <= x_nx;
          dx    <= dx_nx;
          y_r   <= mv_y.pos[9:0];
          dy    <= mv_y.neg;
          busy  <= 1'b0;
          state <= COMMIT;
        end
        COMMIT: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.x_out          = x_r;
  assign bus.y_out          = y_r;
  assign bus.frame_tick_out = tick;
  assign bus.busy_out       = busy;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Randomized scoreboard bench for sprite_motion_ctrl
// against a per-frame position model.
module tb_sprite_motion_ctrl;
  localparam int XMAX = 768;
  localparam int YMAX = 512;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sprite_motion_ctrl_if sif ();

  sprite_motion_ctrl dut (
    .pixel_clk_in(clk),
    .rst_n_in    (rst_n),
    .bus         (sif)
  );

  typedef struct {
    int x;
    int y;
    bit abort;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mx, my, mdx, mdy;
  int cur_x, cur_y;
  bit mon_on = 0;

  task automatic check(input string nm,
                       input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v,
                               input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1;
  endtask

  task automatic model_step(input int mode,
    input int spd, input int u, input int d,
    input int l, input int r);
    int nx, ny;
    if (mode == 0) begin
      nx = mx;
      ny = my;
      if (r != 0 && l == 0) nx = mx + spd;
      if (l != 0 && r == 0) nx = mx - spd;
      if (d != 0 && u == 0) ny = my + spd;
      if (u != 0 && d == 0) ny = my - spd;
      mx = clamp(nx, XMAX);
      my = clamp(ny, YMAX);
    end else if (spd != 0) begin
      nx = mx + mdx * spd;
      ny = my + mdy * spd;
      if (nx >= XMAX) begin mx = XMAX; mdx = -1; end
      else if (nx <= 0) begin mx = 0; mdx = 1; end
      else mx = nx;
      if (ny >= YMAX) begin my = YMAX; mdy = -1; end
      else if (ny <= 0) begin my = 0; mdy = 1; end
      else my = ny;
    end
  endtask

  task automatic idle_counts();
    sif.hcount_in = 11'($urandom_range(1, 1343));
    sif.vcount_in = 10'($urandom_range(0, 805));
  endtask

  task automatic frame(input int mode, input int spd,
    input int u, input int d, input int l,
    input int r, input bit abort, input bit extra);
    exp_t e;
    @(negedge clk);
    sif.mode_in      = mode[0];
    sif.speed_in     = 4'(spd);
    sif.btn_up_in    = u[0];
    sif.btn_down_in  = d[0];
    sif.btn_left_in  = l[0];
    sif.btn_right_in = r[0];
    idle_counts();
    repeat (3) @(negedge clk);
    sif.hcount_in = '0;
    sif.vcount_in = 10'd768;
    if (abort) begin
      model_reset();
      e = '{x: 0, y: 0, abort: 1'b1};
    end else begin
      model_step(mode, spd, u, d, l, r);
      e = '{x: mx, y: my, abort: 1'b0};
    end
    q.push_back(e);
    @(negedge clk);
    idle_counts();
    if (abort) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else if (extra) begin
      @(negedge clk);
      sif.hcount_in = '0;
      sif.vcount_in = 10'd768;
      @(negedge clk);
      idle_counts();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic goto_xy(input int tx, input int ty);
    int dd;
    int sp;
    for (int k = 0; k < 200; k++) begin
      if (mx == tx && my == ty) break;
      if (mx != tx) begin
        dd = tx - mx;
        sp = (dd < 0) ? -dd : dd;
        if (sp > 15) sp = 15;
        frame(0, sp, 0, 0, int'(dd < 0),
              int'(dd > 0), 1'b0, 1'b0);
      end else begin
        dd = ty - my;
        sp = (dd < 0) ? -dd : dd;
        if (sp > 15) sp = 15;
        frame(0, sp, int'(dd < 0), int'(dd > 0),
              0, 0, 1'b0, 1'b0);
      end
    end
  endtask

  // Monitor: each tick pops one expected frame result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!mon_on) continue;
      if (sif.frame_tick_out !== 1'b1) begin
        check("x_stable", int'(sif.x_out), cur_x);
        check("y_stable", int'(sif.y_out), cur_y);
        continue;
      end
      if (q.size() == 0) begin
        check("tick_unexpected", 1, 0);
        continue;
      end
      e = q.pop_front();
      check("busy_t1", int'(sif.busy_out), 1);
      @(negedge clk);
      check("tick_t2", int'(sif.frame_tick_out), 0);
      check("busy_t2", int'(sif.busy_out), 1);
      @(negedge clk);
      if (e.abort) begin
        check("x_abort", int'(sif.x_out), 0);
        check("y_abort", int'(sif.y_out), 0);
        check("busy_abort", int'(sif.busy_out), 0);
        cur_x = 0;
        cur_y = 0;
      end else begin
        check("x_hold", int'(sif.x_out), cur_x);
        check("y_hold", int'(sif.y_out), cur_y);
        check("busy_t3", int'(sif.busy_out), 1);
        @(negedge clk);
        check("x_commit", int'(sif.x_out), e.x);
        check("y_commit", int'(sif.y_out), e.y);
        check("busy_t4", int'(sif.busy_out), 0);
        check("tick_t4", int'(sif.frame_tick_out), 0);
        cur_x = e.x;
        cur_y = e.y;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    sif.mode_in      = 1'b0;
    sif.speed_in     = '0;
    sif.btn_up_in    = 1'b0;
    sif.btn_down_in  = 1'b0;
    sif.btn_left_in  = 1'b0;
    sif.btn_right_in = 1'b0;
    idle_counts();
    repeat (2) @(negedge clk);
    check("rst_x", int'(sif.x_out), 0);
    check("rst_y", int'(sif.y_out), 0);
    check("rst_tick", int'(sif.frame_tick_out), 0);
    check("rst_busy", int'(sif.busy_out), 0);
    rst_n = 1'b1;
    model_reset();
    cur_x = 0;
    cur_y = 0;
    mon_on = 1'b1;

    repeat (3) frame(0, 4, 0, 0, 0, 1, 1'b0, 1'b0);

    goto_xy(766, 0);
    repeat (2) frame(0, 4, 0, 0, 0, 1, 1'b0, 1'b0);

    goto_xy(766, 300);
    repeat (2) frame(1, 4, 0, 0, 0, 0, 1'b0, 1'b0);

    frame(0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    goto_xy(100, 510);
    frame(1, 4, 0, 0, 0, 0, 1'b0, 1'b0);
    goto_xy(100, 2);
    repeat (2) frame(1, 4, 0, 0, 0, 0, 1'b0, 1'b0);
    frame(1, 0, 0, 0, 0, 0, 1'b0, 1'b0);

    goto_xy(100, 100);
    frame(0, 3, 1, 0, 1, 1, 1'b0, 1'b0);

    goto_xy(200, 50);
    frame(0, 5, 0, 0, 0, 1, 1'b1, 1'b0);
    frame(0, 5, 0, 0, 0, 1, 1'b0, 1'b0);

    for (int i = 0; i < 120; i++) begin
      bit ab;
      bit ex;
      ab = ($urandom % 12) == 0;
      ex = !ab && (($urandom % 3) == 0);
      frame(int'($urandom % 2),
            int'($urandom % 16),
            int'($urandom % 2), int'($urandom % 2),
            int'($urandom % 2), int'($urandom % 2),
            ab, ex);
    end

    for (int w = 0; w < 50 && q.size() != 0; w++)
      @(negedge clk);
    if (q.size() != 0)
      check("queue_drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
